// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// Also used by the round-robin picker, which other arbiters reuse.
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_PKT_DEF = 64;

    // A single-requester build still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request
// at or after ptr, wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int c;

    // Scan from the far end so the candidate closest to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX
// serializer; an owner keeps the channel until last or MAX_PKT.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = MAX_PKT_DEF,
    localparam int IW     = idx_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      forced_release
);

    localparam int CW      = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;
    localparam int CNT_END = (MAX_PKT > 0) ? MAX_PKT - 1 : 0;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          forced_q, forced_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          locked;
    logic          owner_valid;
    logic          owner_last;
    logic          xfer;
    logic          cnt_hit;
    logic          rel;
    logic [IW-1:0] next_ptr;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign locked      = (state_q == ARB_LOCKED);
    assign owner_valid = req_valid[grant_id_q];
    assign owner_last  = req_last[grant_id_q];
    assign xfer        = locked & owner_valid & tx_ready;
    assign cnt_hit     = (MAX_PKT != 0) && (pkt_cnt_q == CW'(CNT_END));
    assign rel         = xfer & (owner_last | cnt_hit);
    assign next_ptr    = (grant_id_q == IW'(N_REQ - 1)) ? '0
                                                        : grant_id_q + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            pkt_cnt_q  <= pkt_cnt_d;
            forced_q   <= forced_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        pkt_cnt_d  = pkt_cnt_q;
        forced_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d    = ARB_LOCKED;
                    grant_id_d = pick_idx;
                    busy_d     = 1'b1;
                    pkt_cnt_d  = '0;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    pkt_cnt_d = pkt_cnt_q + CW'(1);
                    if (rel) begin
                        state_d  = ARB_IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                        // A packet whose last byte lands on the limit ends normally.
                        forced_d = cnt_hit & ~owner_last;
                    end
                end
            end
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (locked) begin
            tx_valid              = owner_valid;
            tx_data               = req_data[int'(grant_id_q) * DATA_W +: DATA_W];
            req_ready[grant_id_q] = tx_ready;
        end
    end

    assign grant_id       = grant_id_q;
    assign busy           = busy_q;
    assign forced_release = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (2 requesters, MAX_PKT=4):
// inputs change 1 time unit after posedge, checks 1 unit later.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [0:0]  grant_id;
    logic        busy;
    logic        forced_release;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int forced = 0;

    uart_tx_arbiter #(
        .N_REQ   (2),
        .DATA_W  (8),
        .MAX_PKT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .grant_id       (grant_id),
        .busy           (busy),
        .forced_release (forced_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1)
            xfers++;
        if (forced_release === 1'b1)
            forced++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        tx_ready  = 1'b1;

        // Reset state
        tick();
        settle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_rdy", 32'(req_ready), 0);
        chk("rst_frc", 32'(forced_release), 0);
        rst_n = 1'b1;
        tick();

        // Single packet from requester 0: 48 69 0A
        req_valid = 2'b01;
        req_data[7:0] = 8'h48;
        settle();
        chk("p1_idle_txv", 32'(tx_valid), 0);
        tick();
        settle();
        chk("p1_b0", 32'(tx_data), 32'h48);
        chk("p1_b0_v", 32'(tx_valid), 1);
        chk("p1_busy", 32'(busy), 1);
        chk("p1_rdy", 32'(req_ready), 32'h1);
        tick();
        req_data[7:0] = 8'h69;
        settle();
        chk("p1_b1", 32'(tx_data), 32'h69);
        tick();
        req_data[7:0] = 8'h0A;
        req_last = 2'b01;
        settle();
        chk("p1_b2", 32'(tx_data), 32'h0A);
        tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
        settle();
        chk("p1_rel_busy", 32'(busy), 0);
        chk("p1_rel_txv", 32'(tx_valid), 0);
        chk("p1_rel_frc", 32'(forced_release), 0);

        // Contention with rr_ptr=1: requester 1 first, bubble, then 0
        req_valid = 2'b11;
        req_data  = {8'hB0, 8'hA0};
        settle();
        chk("c_idle_rdy", 32'(req_ready), 0);
        tick();
        settle();
        chk("c_grant1", 32'(grant_id), 1);
        chk("c_b0", 32'(tx_data), 32'hB0);
        chk("c_rdy1", 32'(req_ready), 32'h2);
        tick();
        req_data[15:8] = 8'hB1;
        req_last = 2'b10;
        settle();
        chk("c_b1", 32'(tx_data), 32'hB1);
        chk("c_rdy1b", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b01;
        req_last  = 2'b00;
        settle();
        chk("c_bubble_busy", 32'(busy), 0);
        chk("c_bubble_txv", 32'(tx_valid), 0);
        chk("c_bubble_rdy", 32'(req_ready), 0);
        tick();
        settle();
        chk("c_grant0", 32'(grant_id), 0);
        chk("c_a0", 32'(tx_data), 32'hA0);
        tick();
        req_data[7:0] = 8'hA1;
        req_last = 2'b01;
        settle();
        chk("c_a1", 32'(tx_data), 32'hA1);
        tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
        settle();
        chk("c_rel_busy", 32'(busy), 0);

        // Owner gap: requester 1 holds the lock while idle
        req_valid = 2'b11;
        req_data  = {8'hC0, 8'hD0};
        tick();
        settle();
        chk("g_grant", 32'(grant_id), 1);
        chk("g_c0", 32'(tx_data), 32'hC0);
        tick();
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("g_hold_busy", 32'(busy), 1);
            chk("g_hold_grant", 32'(grant_id), 1);
            chk("g_hold_rdy", 32'(req_ready), 32'h2);
            chk("g_hold_txv", 32'(tx_valid), 0);
            tick();
        end
        req_valid = 2'b11;
        req_data[15:8] = 8'hC1;
        req_last = 2'b10;
        settle();
        chk("g_c1", 32'(tx_data), 32'hC1);
        chk("g_c1_v", 32'(tx_valid), 1);
        tick();
        req_valid = 2'b01;
        req_last  = 2'b00;
        settle();
        chk("g_rel_busy", 32'(busy), 0);
        chk("g_rel_frc", 32'(forced_release), 0);
        tick();
        settle();
        chk("g_grant0", 32'(grant_id), 0);
        chk("g_d0", 32'(tx_data), 32'hD0);

        // Backpressure on requester 0: tx_ready 1,0,0,1
        tick();
        req_data[7:0] = 8'hD1;
        tx_ready = 1'b0;
        settle();
        chk("bp_d1", 32'(tx_data), 32'hD1);
        chk("bp_rdy0", 32'(req_ready), 0);
        tick();
        settle();
        chk("bp_hold_d", 32'(tx_data), 32'hD1);
        chk("bp_hold_v", 32'(tx_valid), 1);
        chk("bp_hold_busy", 32'(busy), 1);
        tick();
        tx_ready = 1'b1;
        req_last = 2'b01;
        settle();
        chk("bp_rdy1", 32'(req_ready), 32'h1);
        chk("bp_d1b", 32'(tx_data), 32'hD1);
        tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
        settle();
        chk("bp_rel_busy", 32'(busy), 0);
        chk("bp_rel_frc", 32'(forced_release), 0);

        // Forced release after 4 bytes, requester 1 waiting
        req_valid = 2'b01;
        req_data[7:0] = 8'hE0;
        settle();
        chk("f_idle_txv", 32'(tx_valid), 0);
        tick();
        settle();
        chk("f_e0", 32'(tx_data), 32'hE0);
        chk("f_e0_frc", 32'(forced_release), 0);
        tick();
        req_data[7:0] = 8'hE1;
        settle();
        chk("f_e1", 32'(tx_data), 32'hE1);
        tick();
        req_data[7:0] = 8'hE2;
        settle();
        chk("f_e2_frc", 32'(forced_release), 0);
        tick();
        req_data  = {8'hF0, 8'hE3};
        req_valid = 2'b11;
        req_last  = 2'b10;
        settle();
        chk("f_e3", 32'(tx_data), 32'hE3);
        chk("f_e3_rdy", 32'(req_ready), 32'h1);
        chk("f_e3_busy", 32'(busy), 1);
        tick();
        req_data[7:0] = 8'hE4;
        settle();
        chk("f_rel_busy", 32'(busy), 0);
        chk("f_rel_frc", 32'(forced_release), 1);
        chk("f_rel_txv", 32'(tx_valid), 0);
        tick();
        settle();
        chk("f_grant1", 32'(grant_id), 1);
        chk("f_pulse_end", 32'(forced_release), 0);
        chk("f_f0", 32'(tx_data), 32'hF0);
        tick();
        req_valid = 2'b01;
        req_last  = 2'b00;
        settle();
        chk("f_f0_rel", 32'(busy), 0);
        chk("f_f0_frc", 32'(forced_release), 0);
        tick();
        settle();
        chk("f_grant0", 32'(grant_id), 0);
        chk("f_e4", 32'(tx_data), 32'hE4);
        tick();
        req_data[7:0] = 8'hE5;
        req_last = 2'b01;
        settle();
        chk("f_e5", 32'(tx_data), 32'hE5);
        tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
        settle();
        chk("f_e5_rel", 32'(busy), 0);
        chk("f_e5_frc", 32'(forced_release), 0);

        // Reset mid-packet after byte 2 of requester 1's packet
        req_valid = 2'b11;
        req_data  = {8'h60, 8'h70};
        tick();
        settle();
        chk("r_grant1", 32'(grant_id), 1);
        tick();
        req_data[15:8] = 8'h61;
        tick();
        req_data[15:8] = 8'h62;
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        settle();
        chk("r_pre_txv", 32'(tx_valid), 1);
        tick();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        req_last = 2'b01;
        settle();
        chk("r_busy", 32'(busy), 0);
        chk("r_txv", 32'(tx_valid), 0);
        chk("r_grant", 32'(grant_id), 0);
        chk("r_rdy", 32'(req_ready), 0);
        tick();
        settle();
        chk("r_restart_grant", 32'(grant_id), 0);
        chk("r_restart_d", 32'(tx_data), 32'h70);
        tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
        settle();
        chk("r_rel_busy", 32'(busy), 0);
        tick();

        chk("total_xfers", 32'(xfers), 21);
        chk("total_forced", 32'(forced), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
